// File: rtl/dvd_motion_scheduler_pkg.sv
// Shared types and grid constants for the DVD sprite motion scheduler.
package dvd_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, STEP, HOLD} state_t;

  localparam int CELL_SHIFT = 5;
  localparam int X_MAX      = (640 >> CELL_SHIFT) - 1;
  localparam int Y_MAX      = (480 >> CELL_SHIFT) - 1;
  localparam int X_W        = 5;
  localparam int Y_W        = 4;
endpackage

// File: rtl/dvd_motion_scheduler_if.sv
// Control inputs and sprite state outputs of the motion scheduler.
interface dvd_motion_if
  import dvd_pkg::*;
#(
  parameter int PX_W = X_W,
  parameter int PY_W = Y_W
);
  logic            vsync_i;
  logic            run;
  logic [3:0]      frame_div;
  logic            start_dir_x;
  logic            start_dir_y;
  logic [PX_W-1:0] pos_x;
  logic [PY_W-1:0] pos_y;
  logic            dir_x;
  logic            dir_y;
  logic            step_pulse;
  logic            bounce_x;
  logic            bounce_y;
  logic            corner_hit;
  logic [2:0]      color_idx;

  modport master (
    output vsync_i, run, frame_div, start_dir_x, start_dir_y,
    input  pos_x, pos_y, dir_x, dir_y, step_pulse, bounce_x, bounce_y,
           corner_hit, color_idx
  );

  modport slave (
    input  vsync_i, run, frame_div, start_dir_x, start_dir_y,
    output pos_x, pos_y, dir_x, dir_y, step_pulse, bounce_x, bounce_y,
           corner_hit, color_idx
  );
endinterface

// File: rtl/dvd_motion_scheduler_axis_stepper.sv
// One axis of the sprite: next position/direction and bounce flag for a step.
module dvd_axis_stepper #(
  parameter int W   = 5,
  parameter int MAX = 19
) (
  input  logic         en,
  input  logic [W-1:0] pos,
  input  logic         dir,
  output logic [W-1:0] pos_nxt,
  output logic         dir_nxt,
  output logic         bounce
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    bounce  = 1'b0;
    if (en) begin
      // >= so a corrupted out-of-range position still turns back
      if (dir ? (pos >= MAX_V) : (pos == '0)) begin
        dir_nxt = ~dir;
        bounce  = 1'b1;
      end else if (dir) begin
        pos_nxt = pos + 1'b1;
      end else begin
        pos_nxt = pos - 1'b1;
      end
    end
  end
endmodule

// File: rtl/dvd_motion_scheduler.sv
// Frame-paced bounce controller for the DVD sprite, fully clocked by clk.
module dvd_motion_scheduler
  import dvd_pkg::*;
#(
  parameter int SX_W        = X_W,
  parameter int SY_W        = Y_W,
  parameter int SX_MAX      = X_MAX,
  parameter int SY_MAX      = Y_MAX,
  parameter int HOLD_FRAMES = 30
) (
  input logic         clk,
  input logic         reset,
  dvd_motion_if.slave mif
);
  localparam int HC_W = $clog2(HOLD_FRAMES + 1);

  logic            v1, v2, tick;
  state_t          state;
  logic [3:0]      fcnt;
  logic [HC_W-1:0] hcnt;
  logic [SX_W-1:0] pos_x, px_n;
  logic [SY_W-1:0] pos_y, py_n;
  logic            dir_x, dir_y, dx_n, dy_n, bx, by, step_en;
  logic            step_pulse, bounce_x, bounce_y, corner_hit;
  logic [2:0]      color_idx;

  assign tick    = v1 & ~v2;
  assign step_en = (state == STEP);

  dvd_axis_stepper #(.W(SX_W), .MAX(SX_MAX)) u_axis_x (
    .en(step_en), .pos(pos_x), .dir(dir_x),
    .pos_nxt(px_n), .dir_nxt(dx_n), .bounce(bx)
  );

  dvd_axis_stepper #(.W(SY_W), .MAX(SY_MAX)) u_axis_y (
    .en(step_en), .pos(pos_y), .dir(dir_y),
    .pos_nxt(py_n), .dir_nxt(dy_n), .bounce(by)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      state      <= IDLE;
      fcnt       <= '0;
      hcnt       <= '0;
      pos_x      <= '0;
      pos_y      <= SY_W'(1);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      color_idx  <= '0;
      step_pulse <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      corner_hit <= 1'b0;
    end else begin
      v1         <= mif.vsync_i;
      v2         <= v1;
      step_pulse <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      corner_hit <= 1'b0;
      case (state)
        IDLE: if (mif.run) begin
          dir_x <= mif.start_dir_x;
          dir_y <= mif.start_dir_y;
          fcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (!mif.run) begin
            hcnt  <= '0;
            state <= IDLE;
          end else if (tick) begin
            if (fcnt >= mif.frame_div) begin
              fcnt  <= '0;
              state <= STEP;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
        end
        STEP: begin
          // the step commits even if run drops in this very cycle
          pos_x      <= px_n;
          pos_y      <= py_n;
          dir_x      <= dx_n;
          dir_y      <= dy_n;
          step_pulse <= 1'b1;
          bounce_x   <= bx;
          bounce_y   <= by;
          corner_hit <= bx & by;
          if (bx | by) color_idx <= color_idx + 3'd1;
          if (!mif.run) begin
            hcnt  <= '0;
            state <= IDLE;
          end else if (bx & by) begin
            hcnt  <= HC_W'(HOLD_FRAMES);
            state <= HOLD;
          end else begin
            state <= WAIT;
          end
        end
        HOLD: begin
          if (!mif.run) begin
            hcnt  <= '0;
            state <= IDLE;
          end else if (tick) begin
            if (hcnt <= HC_W'(1)) begin
              hcnt  <= '0;
              fcnt  <= '0;
              state <= WAIT;
            end else begin
              hcnt <= hcnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mif.pos_x      = pos_x;
  assign mif.pos_y      = pos_y;
  assign mif.dir_x      = dir_x;
  assign mif.dir_y      = dir_y;
  assign mif.step_pulse = step_pulse;
  assign mif.bounce_x   = bounce_x;
  assign mif.bounce_y   = bounce_y;
  assign mif.corner_hit = corner_hit;
  assign mif.color_idx  = color_idx;
endmodule

// File: tb/tb_dvd_motion_scheduler.sv
// Random/directed bench for dvd_motion_scheduler against a per-frame behavioural model.
module tb_dvd_motion_scheduler;
  import dvd_pkg::*;

  localparam int HOLD_FRAMES = 30;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dvd_motion_if #(.PX_W(X_W), .PY_W(Y_W)) mif ();

  dvd_motion_scheduler #(.HOLD_FRAMES(HOLD_FRAMES)) dut (
    .clk(clk), .reset(reset), .mif(mif.slave)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // cumulative pulse counts, sampled away from the active edge
  int t_step = 0, t_bx = 0, t_by = 0, t_cor = 0;
  always @(negedge clk) begin
    t_step += int'(mif.step_pulse);
    t_bx   += int'(mif.bounce_x);
    t_by   += int'(mif.bounce_y);
    t_cor  += int'(mif.corner_hit);
  end

  // behavioural model: mode 0 idle, 1 counting frames, 2 frozen after corner
  int m_mode, m_fcnt, m_hold, m_px, m_py, m_col;
  bit m_dx, m_dy;
  int e_step, e_bx, e_by, e_cor;

  task automatic m_reset();
    m_px = 0; m_py = 1; m_dx = 1; m_dy = 1; m_col = 0;
    m_mode = 0; m_fcnt = 0; m_hold = 0;
  endtask

  task automatic m_run_update();
    if (!mif.run) begin
      m_mode = 0; m_hold = 0;
    end else if (m_mode == 0) begin
      m_dx = mif.start_dir_x; m_dy = mif.start_dir_y; m_fcnt = 0; m_mode = 1;
    end
  endtask

  task automatic m_step();
    bit hx, hy;
    hx = m_dx ? (m_px >= X_MAX) : (m_px == 0);
    hy = m_dy ? (m_py >= Y_MAX) : (m_py == 0);
    if (hx) m_dx = !m_dx; else m_px += m_dx ? 1 : -1;
    if (hy) m_dy = !m_dy; else m_py += m_dy ? 1 : -1;
    e_step++;
    if (hx) e_bx++;
    if (hy) e_by++;
    if (hx || hy) m_col = (m_col + 1) % 8;
    if (hx && hy) begin
      e_cor++; m_mode = 2; m_hold = HOLD_FRAMES;
    end
  endtask

  task automatic m_tick();
    if (m_mode == 1) begin
      if (m_fcnt >= int'(mif.frame_div)) begin
        m_fcnt = 0; m_step();
      end else m_fcnt++;
    end else if (m_mode == 2) begin
      m_hold--;
      if (m_hold == 0) begin
        m_fcnt = 0; m_mode = 1;
      end
    end
  endtask

  function automatic logic [31:0] dut_state();
    return {8'(mif.pos_x), 8'(mif.pos_y), 4'(mif.dir_x), 4'(mif.dir_y), 8'(mif.color_idx)};
  endfunction

  function automatic logic [31:0] mdl_state();
    return {8'(m_px), 8'(m_py), 4'(m_dx), 4'(m_dy), 8'(m_col)};
  endfunction

  // one vsync pulse; compare pulse counts in the window and the settled state
  task automatic frame(input string tag);
    int s0, x0, y0, c0;
    s0 = t_step; x0 = t_bx; y0 = t_by; c0 = t_cor;
    e_step = 0; e_bx = 0; e_by = 0; e_cor = 0;
    @(negedge clk) mif.vsync_i = 1'b1;
    repeat (3) @(negedge clk);
    mif.vsync_i = 1'b0;
    repeat (4) @(negedge clk);
    m_tick();
    chk({tag, "_pulses"},
        {8'(t_step - s0), 8'(t_bx - x0), 8'(t_by - y0), 8'(t_cor - c0)},
        {8'(e_step), 8'(e_bx), 8'(e_by), 8'(e_cor)});
    chk({tag, "_state"}, dut_state(), mdl_state());
  endtask

  task automatic set_run(input bit r, input bit sx, input bit sy);
    @(negedge clk);
    mif.run = r; mif.start_dir_x = sx; mif.start_dir_y = sy;
    repeat (2) @(negedge clk);
    m_run_update();
    chk("run_state", dut_state(), mdl_state());
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    m_reset();
    chk("rst_state", dut_state(), mdl_state());
    chk("rst_pulses", {mif.step_pulse, mif.bounce_x, mif.bounce_y, mif.corner_hit}, 4'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    m_run_update();
  endtask

  // reset lands in the cycle the step would be applied
  task automatic reset_mid_step();
    int s0;
    s0 = t_step;
    @(negedge clk) mif.vsync_i = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    m_reset();
    chk("midrst_state", dut_state(), mdl_state());
    @(negedge clk) mif.vsync_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_nopulse", 32'(t_step - s0), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    m_run_update();
  endtask

  initial begin
    int cor_base;
    reset = 1'b1;
    mif.vsync_i = 1'b0; mif.run = 1'b0; mif.frame_div = 4'd0;
    mif.start_dir_x = 1'b1; mif.start_dir_y = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", dut_state(), {8'd0, 8'd1, 4'd1, 4'd1, 8'd0});
    chk("reset_pulses", {mif.step_pulse, mif.bounce_x, mif.bounce_y, mif.corner_hit}, 4'b0);
    reset = 1'b0;

    // one step per frame from the reset position
    set_run(1, 1, 1);
    repeat (3) frame("div0");
    chk("div0_pos", {8'(mif.pos_x), 8'(mif.pos_y)}, {8'd3, 8'd4});

    // steps only on every 4th frame
    mif.frame_div = 4'd3;
    repeat (8) frame("div3");

    // walk to (5,0) heading +/+, so the sprite meets the far corner
    cor_base = t_cor;
    mif.frame_div = 4'd0;
    set_run(0, 1, 0);
    do_reset();
    set_run(1, 1, 0);
    frame("setup"); frame("setup");
    repeat (3) begin
      set_run(0, 1, 0);
      set_run(1, 1, 0);
      frame("setup");
    end
    repeat (15) frame("to_corner");
    chk("corner_seen", 32'(t_cor - cor_base), 32'd1);
    chk("corner_pos", {8'(mif.pos_x), 8'(mif.pos_y)}, {8'd19, 8'd14});
    repeat (HOLD_FRAMES) frame("hold");
    frame("after_hold");
    chk("after_hold_pos", {8'(mif.pos_x), 8'(mif.pos_y)}, {8'd18, 8'd13});

    // freeze, then resume heading -/-
    set_run(0, 1, 1);
    repeat (5) frame("frozen");
    set_run(1, 0, 0);
    repeat (3) frame("resume");

    reset_mid_step();
    repeat (2) frame("post_midrst");

    repeat (250) begin
      case ($urandom_range(0, 19))
        0:       set_run($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1:       mif.frame_div = 4'($urandom_range(0, 3));
        2:       do_reset();
        3:       reset_mid_step();
        default: frame("rand");
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
